// File: rtl/bw_io_impctl_updn_cal_if.sv
// Signal bundle between the impctl up/down calibration engine and its
// surroundings: comparator input, CSR access, commit request and the
// committed/working code outputs. The block itself uses the slave view.
interface bw_io_impctl_updn_cal_if #(
  parameter int WIDTH = 8
);
  logic             cal_en;
  logic             above;
  logic             we_csr;
  logic [WIDTH-1:0] from_csr;
  logic             upd_req;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] to_csr;
  logic             deltabit;
  logic             locked;

  modport master (
    output cal_en, above, we_csr, from_csr, upd_req,
    input  z, to_csr, deltabit, locked
  );

  modport slave (
    input  cal_en, above, we_csr, from_csr, upd_req,
    output z, to_csr, deltabit, locked
  );
endinterface

// File: rtl/bw_io_impctl_updn_cal.sv
// Up/down impedance-calibration engine. Averages the pad comparator over a
// window, steps a saturating working code (to_csr) by one per decision,
// waits a settle time after every code change, detects dithering (locked)
// and commits the working code to the driver bus z on upd_req. CSR writes
// override both codes.
// Optional build macro: BW_IO_IMPCTL_HYST_EN widens the decision threshold
// to AVG_WIN/4 (dead band); without it a plain majority decides.
module bw_io_impctl_updn_cal #(
  parameter int               WIDTH      = 8,
  parameter int               AVG_WIN    = 16,
  parameter int               SETTLE_CYC = 8,
  parameter int               LOCK_REV   = 4,
  parameter logic [WIDTH-1:0] RESET_CODE = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic                      rclk,
  input  logic                      hard_reset_n,
  bw_io_impctl_updn_cal_if.slave    bus
);

  localparam int NW = $clog2(AVG_WIN) + 2;     // signed vote accumulator
  localparam int VW = $clog2(AVG_WIN);         // samples taken in window
  localparam int SW = $clog2(SETTLE_CYC + 1);  // settle cycles elapsed
  localparam int RW = $clog2(LOCK_REV + 1);    // reversal/hold run length

`ifdef BW_IO_IMPCTL_HYST_EN
  localparam int THRESH = AVG_WIN / 4;
`else
  localparam int THRESH = 1;
`endif

  localparam logic signed [NW-1:0] T_POS    = NW'(THRESH);
  localparam logic signed [NW-1:0] T_NEG    = NW'(-THRESH);
  localparam logic [WIDTH-1:0]     CODE_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DECIDE} state_e;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_e;

  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [WIDTH-1:0]        z_cal_q, z_cal_d;
  logic [WIDTH-1:0]        z_q, z_d;
  logic                    deltabit_q, deltabit_d;
  logic                    locked_q, locked_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [VW-1:0]           vote_q, vote_d;
  logic signed [NW-1:0]    net_q, net_d;
  logic [RW-1:0]           rev_q, rev_d;
  logic                    step_up, step_dn;

  // Next-state logic: window sequencing, decision, lock tracking, overrides.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d  = state_q;
    dir_d    = dir_q;
    z_cal_d  = z_cal_q;
    z_d      = z_q;
    settle_d = settle_q;
    vote_d   = vote_q;
    net_d    = net_q;
    rev_d    = rev_q;
    step_up  = 1'b0;
    step_dn  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cal_en) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      S_SETTLE: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          state_d = S_SAMPLE;
          vote_d  = '0;
          net_d   = '0;
        end
      end
      S_SAMPLE: begin
        net_d  = bus.above ? net_q + NW'(1) : net_q - NW'(1);
        vote_d = vote_q + VW'(1);
        if (vote_q == VW'(AVG_WIN - 1)) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        // A decision that would leave the code range is treated as a hold.
        step_up = (net_q >= T_POS) && (z_cal_q != CODE_MAX);
        step_dn = (net_q <= T_NEG) && (z_cal_q != '0) && !step_up;
        if (step_up || step_dn) begin
          z_cal_d  = step_up ? z_cal_q + WIDTH'(1) : z_cal_q - WIDTH'(1);
          dir_d    = step_up ? DIR_UP : DIR_DN;
          state_d  = S_SETTLE;
          settle_d = '0;
          if ((step_up && dir_q == DIR_DN) || (step_dn && dir_q == DIR_UP)) begin
            if (rev_q != RW'(LOCK_REV)) rev_d = rev_q + RW'(1);
          end else begin
            rev_d = '0;
          end
        end else begin
          if (rev_q != RW'(LOCK_REV)) rev_d = rev_q + RW'(1);
          state_d = S_SAMPLE;
          vote_d  = '0;
          net_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    locked_d = locked_q | (rev_d == RW'(LOCK_REV));

    // Commit samples the working code before any step taken this cycle.
    if (bus.upd_req) z_d = z_cal_q;

    // Disabling calibration discards the window and restarts lock tracking.
    if (!bus.cal_en) begin
      state_d  = S_IDLE;
      z_cal_d  = z_cal_q;
      rev_d    = '0;
      dir_d    = DIR_NONE;
      locked_d = 1'b0;
    end

    // CSR write wins over everything else in the same cycle.
    if (bus.we_csr) begin
      z_cal_d  = bus.from_csr;
      z_d      = bus.from_csr;
      state_d  = bus.cal_en ? S_SETTLE : S_IDLE;
      settle_d = '0;
      rev_d    = '0;
      dir_d    = DIR_NONE;
      locked_d = 1'b0;
    end

    deltabit_d = (z_d != z_q);
  end

  // State register; reset returns to IDLE with both codes at RESET_CODE.
  always_ff @(posedge rclk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q    <= S_IDLE;
      dir_q      <= DIR_NONE;
      z_cal_q    <= RESET_CODE;
      z_q        <= RESET_CODE;
      deltabit_q <= 1'b0;
      locked_q   <= 1'b0;
      settle_q   <= '0;
      vote_q     <= '0;
      net_q      <= '0;
      rev_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      dir_q      <= dir_d;
      z_cal_q    <= z_cal_d;
      z_q        <= z_d;
      deltabit_q <= deltabit_d;
      locked_q   <= locked_d;
      settle_q   <= settle_d;
      vote_q     <= vote_d;
      net_q      <= net_d;
      rev_q      <= rev_d;
    end
  end

  assign bus.z        = z_q;
  assign bus.to_csr   = z_cal_q;
  assign bus.deltabit = deltabit_q;
  assign bus.locked   = locked_q;

endmodule
